// File: rtl/lcd_spi_pkg.sv
// Shared definitions for the LCD SPI arbitration slice.
//   LCD_DW / LCD_DC_BIT : LCD word width and position of the D/C flag
//                         (0 = command, 1 = data; payload in [LCD_DW-2:0])
//   arb_state_e         : one-hot arbiter state encoding
//   LCD_CMD_*           : LCD command codes used by requesters and benches
//   lcd_word()          : builds a word from D/C flag and payload
package lcd_spi_pkg;

  localparam int unsigned LCD_DW     = 9;
  localparam int unsigned LCD_DC_BIT = LCD_DW - 1;

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_ISSUE = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_ACK   = 5'b01000,
    ST_HOLD  = 5'b10000
  } arb_state_e;

  localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
  localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  function automatic logic [LCD_DW-1:0] lcd_word(input logic dc, input logic [LCD_DW-2:0] payload);
    return {dc, payload};
  endfunction

endpackage

// File: rtl/lcd_rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot first requester at/after ptr (wrapping), 0 if none
//   idx   : binary index of grant (0 if none)
module lcd_rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx
);

  always_comb begin
    logic          found;
    logic [PW-1:0] k;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = PW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_arbiter.sv
// Shares one LCD SPI word writer between NUM_REQ requesters. Round-robin
// grant per word; an owner holding lock keeps the writer for bursts, with a
// forced release after LOCK_TIMEOUT idle cycles in HOLD.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_i       : per-requester request, held with its word until ack_o
//   lock_i      : keep ownership after the current word
//   wdata_i     : word of requester k at [k*DW +: DW]
//   ack_o       : 1-cycle pulse, word of requester k written
//   grant_o     : one-hot current owner, 0 when free
//   busy_o      : high in every state except IDLE
//   spi_en_o    : 1-cycle start strobe to the SPI writer
//   spi_data_o  : word to the SPI writer, stable from ISSUE until done
//   spi_done_i  : 1-cycle completion pulse from the SPI writer
module lcd_spi_arbiter
  import lcd_spi_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned DW           = LCD_DW,
  parameter int unsigned LOCK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    lock_i,
  input  logic [NUM_REQ*DW-1:0] wdata_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic                  busy_o,
  output logic                  spi_en_o,
  output logic [DW-1:0]         spi_data_o,
  input  logic                  spi_done_i
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  arb_state_e           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_d, ack_d;
  logic [DW-1:0]        data_d;
  logic                 en_d, busy_d, release_now;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [PW-1:0]        pick_idx;

  lcd_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_picker (
    .req   (req_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      grant_o    <= '0;
      ack_o      <= '0;
      spi_data_o <= '0;
      spi_en_o   <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      grant_o    <= grant_d;
      ack_o      <= ack_d;
      spi_data_o <= data_d;
      spi_en_o   <= en_d;
      busy_o     <= busy_d;
    end
  end

  // Outputs are registered: every *_d below is the value seen in the cycle
  // of state_d, so the strobe and ack line up with ISSUE and ACK.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    grant_d     = grant_o;
    data_d      = spi_data_o;
    ack_d       = '0;
    en_d        = 1'b0;
    release_now = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          owner_d = pick_idx;
          grant_d = pick_grant;
          data_d  = wdata_i[pick_idx*DW +: DW];
          en_d    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (spi_done_i) begin
          ack_d[owner_q] = 1'b1;
          state_d        = ST_ACK;
        end
      end
      ST_ACK: begin
        if (lock_i[owner_q]) begin
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          release_now = 1'b1;
        end
      end
      ST_HOLD: begin
        if (req_i[owner_q]) begin
          data_d  = wdata_i[owner_q*DW +: DW];
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end else if (!lock_i[owner_q] || cnt_q == CNT_LAST) begin
          release_now = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Any release (normal, lock dropped, timeout) moves the owner to the
    // back of the round-robin order.
    if (release_now) begin
      state_d = ST_IDLE;
      grant_d = '0;
      ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
module tb_lcd_spi_arbiter;
  import lcd_spi_pkg::*;

  typedef struct packed {
    logic [8:0] w;
    logic       l;
  } src_t;

  typedef struct {
    int         owner;
    logic [8:0] w;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_i, lock_i, ack_o, grant_o;
  logic [17:0] wdata_i;
  logic        busy_o, spi_en_o, spi_done_i;
  logic [8:0]  spi_data_o;

  logic        rq0, rq1, lk0, lk1;
  logic [8:0]  wd0, wd1;
  logic        done_a, done_m;
  logic        spi_auto;
  int          spi_lat, epoch;
  int          errors, checks;
  int          model_ptr;

  exp_t        exp_q[$];
  int          ack_q[$];
  src_t        src0[$], src1[$];

  assign req_i      = {rq1, rq0};
  assign lock_i     = {lk1, lk0};
  assign wdata_i    = {wd1, wd0};
  assign spi_done_i = done_a | done_m;

  lcd_spi_arbiter #(
    .NUM_REQ      (2),
    .DW           (9),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .lock_i     (lock_i),
    .wdata_i    (wdata_i),
    .ack_o      (ack_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .spi_en_o   (spi_en_o),
    .spi_data_o (spi_data_o),
    .spi_done_i (spi_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [8:0] w);
    exp_t e;
    e.owner = k;
    e.w     = w;
    exp_q.push_back(e);
    ack_q.push_back(k);
  endtask

  task automatic wait_ack(input int k, input int maxc, output int n);
    bit ok;
    ok = 0;
    n  = 0;
    while (!ok && n < maxc) begin
      @(negedge clk);
      n++;
      if (((ack_o >> k) & 2'b01) != 0) ok = 1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout_%0d: no ack after %0d cycles", k, maxc);
    end
  endtask

  // SPI writer model: answers each start strobe with a done pulse after a
  // latency; a reset (epoch bump) abandons the pending transfer.
  int mdl_ep, mdl_lat;
  always begin
    @(negedge clk);
    if (spi_auto && rst_n && spi_en_o) begin
      mdl_ep  = epoch;
      mdl_lat = (spi_lat > 0) ? spi_lat : int'($urandom_range(1, 6));
      for (int i = 0; i < mdl_lat && mdl_ep == epoch; i++) @(negedge clk);
      if (mdl_ep == epoch) begin
        done_a = 1'b1;
        @(negedge clk);
        done_a = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every issued word and every ack is matched against
  // the expected order pushed by the stimulus.
  exp_t mon_e;
  int   mon_a;
  always @(negedge clk) begin
    if (rst_n) begin
      if (spi_en_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_issue: unexpected word 0x%0h none pending", spi_data_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_owner", 32'(grant_o), 32'(1 << mon_e.owner));
          chk("sb_data", 32'(spi_data_o), 32'(mon_e.w));
        end
      end
      if (ack_o != 2'b00) begin
        if (ack_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_ack: unexpected ack 0x%0h none pending", ack_o);
        end else begin
          mon_a = ack_q.pop_front();
          chk("sb_ack", 32'(ack_o), 32'(1 << mon_a));
        end
      end
    end
  end

  // Drives the word lists of both requesters, holding each word until acked.
  // A word's lock stays valid through the ACK cycle, then follows the next word.
  task automatic run_lists(input int d0, input int d1);
    int cyc;
    bit a0, a1, u0, u1;
    logic n0, n1;
    cyc = 0; a0 = 0; a1 = 0; u0 = 0; u1 = 0; n0 = 0; n1 = 0;
    while ((src0.size() > 0 || src1.size() > 0) && cyc < 5000) begin
      if (!a0 && src0.size() > 0 && cyc >= d0) begin
        wd0 = src0[0].w; lk0 = src0[0].l; rq0 = 1'b1; a0 = 1;
      end
      if (!a1 && src1.size() > 0 && cyc >= d1) begin
        wd1 = src1[0].w; lk1 = src1[0].l; rq1 = 1'b1; a1 = 1;
      end
      @(negedge clk);
      cyc++;
      if (u0) begin lk0 = n0; u0 = 0; end
      if (u1) begin lk1 = n1; u1 = 0; end
      if (ack_o[0]) begin
        void'(src0.pop_front());
        if (src0.size() > 0) begin wd0 = src0[0].w; n0 = src0[0].l; end
        else begin rq0 = 1'b0; n0 = 1'b0; a0 = 0; end
        u0 = 1;
      end
      if (ack_o[1]) begin
        void'(src1.pop_front());
        if (src1.size() > 0) begin wd1 = src1[0].w; n1 = src1[0].l; end
        else begin rq1 = 1'b0; n1 = 1'b0; a1 = 0; end
        u1 = 1;
      end
    end
    if (cyc >= 5000) begin
      checks++;
      errors++;
      $display("FAIL run_lists_timeout: %0d words left", src0.size() + src1.size());
    end
    @(negedge clk);
    lk0 = 1'b0;
    lk1 = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    n;
    logic [8:0] w0, w1;
    src_t  q0[$], q1[$];
    src_t  s;
    int    p, k;

    rst_n = 1'b0; rq0 = 0; rq1 = 0; lk0 = 0; lk1 = 0; wd0 = '0; wd1 = '0;
    done_a = 0; done_m = 0; spi_auto = 1; spi_lat = 0; epoch = 0;
    errors = 0; checks = 0; model_ptr = 0;

    // Reset values
    #3;
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_ack", 32'(ack_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_en", 32'(spi_en_o), 0);
    chk("rst_data", 32'(spi_data_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 0);

    // Single word with a 16-cycle SPI transfer
    spi_lat = 16;
    push_exp(0, 9'h02A);
    wd0 = 9'h02A; rq0 = 1'b1;
    @(negedge clk);
    chk("t1_grant", 32'(grant_o), 32'h1);
    chk("t1_en", 32'(spi_en_o), 1);
    chk("t1_busy", 32'(busy_o), 1);
    @(negedge clk);
    chk("t1_en_pulse", 32'(spi_en_o), 0);
    chk("t1_data_hold", 32'(spi_data_o), 32'h02A);
    wait_ack(0, 40, n);
    chk("t1_ack_latency", 32'(n), 16);
    chk("t1_ack", 32'(ack_o), 32'h1);
    rq0 = 1'b0;
    @(negedge clk);
    chk("t1_ack_len", 32'(ack_o), 0);
    chk("t1_busy_low", 32'(busy_o), 0);
    chk("t1_grant_free", 32'(grant_o), 0);
    spi_lat = 0;

    // Spurious done in IDLE, ISSUE and HOLD
    spi_auto = 0;
    done_m = 1'b1; @(negedge clk); done_m = 1'b0;
    chk("t6_idle_busy", 32'(busy_o), 0);
    chk("t6_idle_ack", 32'(ack_o), 0);
    push_exp(1, 9'h155);
    wd1 = 9'h155; rq1 = 1'b1; lk1 = 1'b1;
    @(negedge clk);
    chk("t6_issue_en", 32'(spi_en_o), 1);
    done_m = 1'b1; @(negedge clk); done_m = 1'b0;
    chk("t6_issue_noack", 32'(ack_o), 0);
    chk("t6_issue_busy", 32'(busy_o), 1);
    repeat (2) @(negedge clk);
    chk("t6_still_wait", 32'(ack_o), 0);
    done_m = 1'b1; @(negedge clk); done_m = 1'b0;
    chk("t6_real_ack", 32'(ack_o), 32'h2);
    rq1 = 1'b0;
    @(negedge clk);
    done_m = 1'b1; @(negedge clk); done_m = 1'b0;
    chk("t6_hold_noack", 32'(ack_o), 0);
    chk("t6_hold_grant", 32'(grant_o), 32'h2);
    chk("t6_hold_en", 32'(spi_en_o), 0);
    lk1 = 1'b0;
    @(negedge clk);
    chk("t6_unlock_grant", 32'(grant_o), 0);
    chk("t6_unlock_busy", 32'(busy_o), 0);
    spi_auto = 1;

    // Reset during WAIT: pointer left at 1 by requester 0's word must return to 0
    w0 = 9'($urandom_range(0, 511));
    src0.push_back('{w: w0, l: 1'b0});
    push_exp(0, w0);
    run_lists(0, 0);
    spi_lat = 20;
    w1 = 9'($urandom_range(0, 511));
    push_exp(1, w1);
    wd1 = w1; rq1 = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    epoch++;
    #1;
    chk("t5_grant", 32'(grant_o), 0);
    chk("t5_busy", 32'(busy_o), 0);
    chk("t5_en", 32'(spi_en_o), 0);
    chk("t5_data", 32'(spi_data_o), 0);
    chk("t5_ack", 32'(ack_o), 0);
    exp_q.delete();
    ack_q.delete();
    rq1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spi_lat = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_post_ack", 32'(ack_o), 0);
      chk("t5_post_busy", 32'(busy_o), 0);
    end

    // Fairness from reset: both requesting, 4 words each, alternating from 0
    for (int i = 0; i < 4; i++) begin
      w0 = 9'($urandom_range(0, 511));
      w1 = 9'($urandom_range(0, 511));
      src0.push_back('{w: w0, l: 1'b0});
      src1.push_back('{w: w1, l: 1'b0});
      push_exp(0, w0);
      push_exp(1, w1);
    end
    run_lists(0, 0);

    // Locked RAMWR burst from requester 1 with requester 0 arriving late
    src1.push_back('{w: lcd_word(1'b0, LCD_CMD_RAMWR), l: 1'b1});
    src1.push_back('{w: 9'h1F8, l: 1'b1});
    src1.push_back('{w: 9'h100, l: 1'b0});
    src0.push_back('{w: 9'h0AA, l: 1'b0});
    push_exp(1, 9'h02C);
    push_exp(1, 9'h1F8);
    push_exp(1, 9'h100);
    push_exp(0, 9'h0AA);
    run_lists(3, 0);

    // Lock timeout: owner 1 keeps lock without requesting
    w0 = 9'($urandom_range(0, 511));
    w1 = 9'($urandom_range(0, 511));
    push_exp(1, w1);
    push_exp(0, w0);
    wd1 = w1; rq1 = 1'b1; lk1 = 1'b1;
    @(negedge clk);
    wd0 = w0; rq0 = 1'b1;
    wait_ack(1, 50, n);
    rq1 = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 8) chk("t4_held", 32'(grant_o), 32'h2);
      if (i == 9) begin
        chk("t4_released", 32'(grant_o), 0);
        chk("t4_released_busy", 32'(busy_o), 0);
      end
      if (i == 10) chk("t4_next_grant", 32'(grant_o), 32'h1);
    end
    lk1 = 1'b0;
    wait_ack(0, 50, n);
    rq0 = 1'b0;
    @(negedge clk);
    model_ptr = 1;

    // Random rounds: bursts alternate between requesters, starting at the
    // requester after the last released owner
    for (int r = 0; r < 8; r++) begin
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        n = int'($urandom_range(1, 3));
        for (int j = 0; j < n; j++) src0.push_back('{w: 9'($urandom_range(0, 511)), l: (j != n - 1)});
      end
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        n = int'($urandom_range(1, 3));
        for (int j = 0; j < n; j++) src1.push_back('{w: 9'($urandom_range(0, 511)), l: (j != n - 1)});
      end
      q0 = src0;
      q1 = src1;
      p  = model_ptr;
      while (q0.size() > 0 || q1.size() > 0) begin
        if (q0.size() == 0) k = 1;
        else if (q1.size() == 0) k = 0;
        else k = p;
        do begin
          s = (k == 0) ? q0.pop_front() : q1.pop_front();
          push_exp(k, s.w);
        end while (s.l && ((k == 0) ? q0.size() : q1.size()) > 0);
        p = (k + 1) % 2;
      end
      model_ptr = p;
      run_lists(0, 0);
    end

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size() + ack_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
